// File: rtl/trigger_pkg.sv
// Shared types and default constants for the go/stop trigger generator.
// Holds the holdoff FSM state encoding and the counter-width helper.
package trigger_pkg;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_HOLDOFF_CYCLES  = 8;

  // Two-bit encoding leaves spare codes so recovery from a corrupted state is explicit.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_HOLDOFF = 2'b01
  } trig_state_e;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Per-button 2-flop synchronizer, counter-qualified debounce and rising-edge detect.
// o_rise is high for exactly one cycle after the debounced level goes high.
module btn_debounce
  import trigger_pkg::*;
#(
  parameter int p_DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);

  localparam int                  lp_CNT_W   = cnt_width(p_DEBOUNCE_CYCLES);
  localparam logic [lp_CNT_W-1:0] lp_CNT_MAX = lp_CNT_W'(p_DEBOUNCE_CYCLES - 1);

  logic                r_sync1;
  logic                r_sync2;
  logic                r_level;
  logic                r_level_d;
  logic [lp_CNT_W-1:0] r_cnt;

  // NOTE: reset is synchronous, so every flop (including the counter) clears only on a clock edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == lp_CNT_MAX) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + lp_CNT_W'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_level & ~r_level_d;

endmodule

// File: rtl/go_stop_trigger_gen.sv
// Go/stop trigger generator: debounced buttons feed a holdoff FSM that emits
// registered one-cycle go/stop strobes and a busy flag during holdoff.
module go_stop_trigger_gen
  import trigger_pkg::*;
#(
  parameter int p_DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int p_HOLDOFF_CYCLES  = DEF_HOLDOFF_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn_go,
  input  logic i_btn_stop,
  output logic o_go,
  output logic o_stop,
  output logic o_busy
);

  localparam int                   lp_HOLD_W    = cnt_width(p_HOLDOFF_CYCLES);
  localparam logic [lp_HOLD_W-1:0] lp_HOLD_LOAD = lp_HOLD_W'(p_HOLDOFF_CYCLES - 1);

  logic w_go_level, w_go_rise;
  logic w_stop_level, w_stop_rise;
  // Debounced levels are not needed here; tie them off into one named sink.
  logic w_unused_levels;

  trig_state_e          r_state, w_state_nxt;
  logic [lp_HOLD_W-1:0] r_hold_cnt, w_hold_cnt_nxt;
  logic                 r_go, r_stop, r_busy;
  logic                 w_go_nxt, w_stop_nxt, w_busy_nxt;

  btn_debounce #(.p_DEBOUNCE_CYCLES(p_DEBOUNCE_CYCLES)) u_db_go (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_btn   (i_btn_go),
    .o_level (w_go_level),
    .o_rise  (w_go_rise)
  );

  btn_debounce #(.p_DEBOUNCE_CYCLES(p_DEBOUNCE_CYCLES)) u_db_stop (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_btn   (i_btn_stop),
    .o_level (w_stop_level),
    .o_rise  (w_stop_rise)
  );

  assign w_unused_levels = w_go_level ^ w_stop_level;

  // NOTE: combinational block assigns every output a default first, so no latch is inferred.
  always_comb begin
    w_state_nxt    = r_state;
    w_hold_cnt_nxt = r_hold_cnt;
    w_go_nxt       = 1'b0;
    w_stop_nxt     = 1'b0;
    w_busy_nxt     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_stop_rise) begin
          w_stop_nxt = 1'b1;
        end else if (w_go_rise) begin
          w_go_nxt       = 1'b1;
          w_busy_nxt     = 1'b1;
          w_hold_cnt_nxt = lp_HOLD_LOAD;
          w_state_nxt    = ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        // Go rises here are dropped; stop aborts the holdoff immediately.
        if (w_stop_rise) begin
          w_stop_nxt     = 1'b1;
          w_hold_cnt_nxt = '0;
          w_state_nxt    = ST_IDLE;
        end else if (r_hold_cnt == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt - lp_HOLD_W'(1);
          w_busy_nxt     = 1'b1;
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_hold_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_hold_cnt <= '0;
      r_go       <= 1'b0;
      r_stop     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_go       <= w_go_nxt;
      r_stop     <= w_stop_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign o_go   = r_go;
  assign o_stop = r_stop;
  assign o_busy = r_busy;

endmodule

// File: tb/tb_go_stop_trigger_gen.sv
// Directed bench for go_stop_trigger_gen at 4 debounce / 8 holdoff cycles.
// "k" in comments is the first rising edge that samples the new raw input level.
module tb_go_stop_trigger_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_go = 1'b0;
  logic btn_stop = 1'b0;
  logic o_go, o_stop, o_busy;

  int checks = 0;
  int errors = 0;

  go_stop_trigger_gen #(
    .p_DEBOUNCE_CYCLES(4),
    .p_HOLDOFF_CYCLES (8)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_btn_go   (btn_go),
    .i_btn_stop (btn_stop),
    .o_go       (o_go),
    .o_stop     (o_stop),
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic eg, input logic es, input logic eb);
    checks++;
    assert (o_go === eg) else begin
      errors++;
      $error("FAIL %s o_go: got %b expected %b", tag, o_go, eg);
    end
    checks++;
    assert (o_stop === es) else begin
      errors++;
      $error("FAIL %s o_stop: got %b expected %b", tag, o_stop, es);
    end
    checks++;
    assert (o_busy === eb) else begin
      errors++;
      $error("FAIL %s o_busy: got %b expected %b", tag, o_busy, eb);
    end
  endtask

  initial begin
    // Reset state, then first cycle after release.
    tick(3);
    check("reset", 0, 0, 0);
    rst_n = 1'b1;
    tick(1);
    check("post_reset", 0, 0, 0);
    tick(3);

    // Clean go: strobe after edge k+6, busy for 8 cycles.
    btn_go = 1'b1;
    for (int i = 0; i < 6; i++) begin tick(1); check("clean_pre", 0, 0, 0); end
    tick(1); check("clean_go", 1, 0, 1);
    for (int i = 0; i < 7; i++) begin tick(1); check("clean_hold", 0, 0, 1); end
    tick(1); check("clean_done", 0, 0, 0);
    btn_go = 1'b0;
    tick(10);

    // Bounce: 1/0 every 2 cycles for 20 cycles, then hold high.
    for (int i = 0; i < 5; i++) begin
      btn_go = 1'b1;
      tick(1); check("bounce", 0, 0, 0);
      tick(1); check("bounce", 0, 0, 0);
      btn_go = 1'b0;
      tick(1); check("bounce", 0, 0, 0);
      tick(1); check("bounce", 0, 0, 0);
    end
    btn_go = 1'b1;
    for (int i = 0; i < 6; i++) begin tick(1); check("bounce_pre", 0, 0, 0); end
    tick(1); check("bounce_go", 1, 0, 1);
    for (int i = 0; i < 7; i++) begin tick(1); check("bounce_hold", 0, 0, 1); end
    tick(1); check("bounce_done", 0, 0, 0);
    btn_go = 1'b0;
    tick(10);

    // Holdoff drop: 4-cycle press, 4-cycle release, re-press -> rise at k+13 while busy.
    btn_go = 1'b1;
    tick(4);
    btn_go = 1'b0;
    tick(3); check("drop_go", 1, 0, 1);
    tick(1); check("drop_hold", 0, 0, 1);
    btn_go = 1'b1;
    for (int i = 0; i < 6; i++) begin tick(1); check("drop_hold", 0, 0, 1); end
    tick(1); check("drop_discard", 0, 0, 0);
    for (int i = 0; i < 6; i++) begin tick(1); check("drop_idle", 0, 0, 0); end
    btn_go = 1'b0;
    tick(10);
    btn_go = 1'b1;
    for (int i = 0; i < 6; i++) begin tick(1); check("after_pre", 0, 0, 0); end
    tick(1); check("after_go", 1, 0, 1);
    for (int i = 0; i < 7; i++) begin tick(1); check("after_hold", 0, 0, 1); end
    tick(1); check("after_done", 0, 0, 0);
    btn_go = 1'b0;
    tick(10);

    // Stop abort 3 cycles into holdoff; the next go rise at k+13 must be accepted.
    btn_go = 1'b1;
    tick(3);
    btn_stop = 1'b1;
    tick(1);
    btn_go = 1'b0;
    tick(3); check("abort_go", 1, 0, 1);
    tick(1); check("abort_hold", 0, 0, 1);
    btn_go = 1'b1;
    tick(1); check("abort_hold", 0, 0, 1);
    tick(1); check("abort_stop", 0, 1, 0);
    tick(1); check("abort_after", 0, 0, 0);
    btn_stop = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(1); check("abort_idle", 0, 0, 0); end
    tick(1); check("abort_new_go", 1, 0, 1);
    for (int i = 0; i < 7; i++) begin tick(1); check("abort_new_hold", 0, 0, 1); end
    tick(1); check("abort_new_done", 0, 0, 0);
    btn_go = 1'b0;
    tick(10);

    // Simultaneous rise: stop wins.
    btn_go = 1'b1;
    btn_stop = 1'b1;
    for (int i = 0; i < 6; i++) begin tick(1); check("simul_pre", 0, 0, 0); end
    tick(1); check("simul_stop", 0, 1, 0);
    tick(1); check("simul_after", 0, 0, 0);
    btn_go = 1'b0;
    btn_stop = 1'b0;
    tick(10);

    // Reset mid-holdoff with go held high.
    btn_go = 1'b1;
    tick(7); check("rst_go", 1, 0, 1);
    tick(2); check("rst_hold", 0, 0, 1);
    rst_n = 1'b0;
    tick(1); check("rst_during", 0, 0, 0);
    tick(1); check("rst_during", 0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin tick(1); check("rst_release_pre", 0, 0, 0); end
    tick(1); check("rst_release_go", 1, 0, 1);
    tick(1); check("rst_release_hold", 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/go_stop_trigger_gen.md
GO_STOP_TRIGGER_GEN -- requirements
Module: go_stop_trigger_gen

Interface
REQ-001 SHALL have parameter p_DEBOUNCE_CYCLES, default 4, which sets the number of consecutive stable synchronized samples needed to accept a level change (legal range >=2).
REQ-002 SHALL have parameter p_HOLDOFF_CYCLES, default 8, which sets the minimum spacing in cycles between o_go strobes (legal range >=2).
REQ-003 SHALL have port i_clk, input, 1 bit: clock; all state changes on the rising edge.
REQ-004 SHALL have port i_rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port i_btn_go, input, 1 bit: asynchronous, bouncy "go" request, active-high.
REQ-006 SHALL have port i_btn_stop, input, 1 bit: asynchronous, bouncy "stop" request, active-high.
REQ-007 SHALL have port o_go, output, 1 bit: one-cycle go strobe for the downstream one-shot pulse generator.
REQ-008 SHALL have port o_stop, output, 1 bit: one-cycle stop strobe for the downstream one-shot pulse generator.
REQ-009 SHALL have port o_busy, output, 1 bit: high while in holdoff, when go requests are being dropped.

Function
REQ-010 SHALL pass each button input through a 2-flop synchronizer before any other logic.
REQ-011 Per input, SHALL keep a debounced level and a counter; the counter increments on each edge where the synchronized level differs from the debounced level.
REQ-012 Per input, the counter SHALL clear to 0 on any edge where the synchronized level equals the debounced level, so a bounce restarts qualification.
REQ-013 Per input, on the edge where the counter equals p_DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level SHALL take the synchronized value and the counter SHALL clear.
REQ-014 Rising-edge detect on each debounced level SHALL be registered; falling edges SHALL produce no strobe.
REQ-015 Latency: raw input first sampled high at edge k and held stable SHALL make the corresponding strobe high exactly between edge k+p_DEBOUNCE_CYCLES+2 and edge k+p_DEBOUNCE_CYCLES+3.
REQ-016 SHALL have FSM states IDLE and HOLDOFF.
REQ-017 IDLE + go edge + no stop edge: SHALL assert o_go for one cycle, load the holdoff counter, and go to HOLDOFF.
REQ-018 HOLDOFF: o_busy SHALL be high for exactly p_HOLDOFF_CYCLES cycles, counted from and including the o_go cycle, then the FSM SHALL return to IDLE.
REQ-019 Go edges in HOLDOFF SHALL be discarded, not queued; o_go SHALL stay 0.
REQ-020 Stop edge in any state SHALL assert o_stop for one cycle with the same latency as o_go.
REQ-021 Stop edge in HOLDOFF SHALL also return the FSM to IDLE on the next cycle and clear the holdoff counter.
REQ-022 Go and stop edges in the same cycle: stop SHALL win; o_stop SHALL be 1, o_go SHALL be 0, and the FSM SHALL be IDLE afterwards.
REQ-023 o_go and o_stop SHALL never be high in the same cycle and SHALL never be high for two consecutive cycles.
REQ-024 Counter widths SHALL be $clog2 of the parameter (minimum 1 bit), and counters SHALL NOT wrap past their terminal count.
REQ-025 An unreachable state encoding SHALL recover to IDLE with all outputs 0.

Reset
REQ-026 With i_rst_n low at a rising edge, synchronizers, debounced levels, edge-detect registers, and counters SHALL go to 0, and the FSM SHALL go to IDLE.
REQ-027 During reset and the first cycle after it, o_go, o_stop, and o_busy SHALL be 0.
REQ-028 Reset mid-holdoff or mid-debounce SHALL discard all progress; a button held high through reset release SHALL yield one strobe with latency counted from the first post-reset edge.

Structure
REQ-029 The FSM state enum and default parameter constants SHALL live in a shared package, trigger_pkg.
REQ-030 The synchronizer, debounce, and rising-edge logic SHALL be one sub-module, btn_debounce (parameter p_DEBOUNCE_CYCLES; ports i_clk, i_rst_n, i_btn, o_level, o_rise), instantiated twice.
REQ-031 The top level SHALL contain only the holdoff FSM, the holdoff counter, and the output registers.

Verification (p_DEBOUNCE_CYCLES=4, p_HOLDOFF_CYCLES=8)
REQ-032 Clean go: i_btn_go high from edge 10 and held -> o_go high only between edges 16 and 17, o_busy high edges 16..24.
REQ-033 Bounce: i_btn_go toggles 1/0 every 2 cycles for 20 cycles, then holds 1 -> exactly one o_go, 6 edges after the first sampled edge of the stable high.
REQ-034 Holdoff drop: second clean go press whose edge lands while o_busy=1 -> no second o_go; a press after o_busy falls -> o_go fires.
REQ-035 Stop abort: go, then a stop whose strobe lands 3 cycles into holdoff -> one-cycle o_stop, o_busy low on the next cycle, and an immediate new go accepted.
REQ-036 Simultaneous: both buttons rise on the same edge -> o_stop=1, o_go=0, o_busy=0.
REQ-037 Reset: assert i_rst_n=0 for 2 cycles mid-holdoff with go held high -> outputs 0 during reset, then one o_go at 6 edges after release.
